// File: rtl/votador_n_pkg.sv
// Shared definitions for the votador_n voting block: FSM state encoding,
// default timeout and the counter-width helper.
package votador_n_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      VOTA = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int DEF_TIMEOUT = 16;

   // Width able to hold a count from 0 to n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/votador_n_if.sv
// Session/vote bus between the voter sources and votador_n.
interface votador_n_if
   import votador_n_pkg::*;
   #(parameter int N = 3) ();

   localparam int W = cnt_w(N);

   logic          start;
   logic [N-1:0]  vote_valid;
   logic [N-1:0]  vote_val;
   logic          busy;
   logic [N-1:0]  voted;
   logic          done;
   logic          timed_out;
   logic          v;
   logic [W-1:0]  yes_cnt;

   modport master (
      output start, vote_valid, vote_val,
      input  busy, voted, done, timed_out, v, yes_cnt
   );

   modport slave (
      input  start, vote_valid, vote_val,
      output busy, voted, done, timed_out, v, yes_cnt
   );

endinterface

// File: rtl/votador_n_popcnt.sv
// votador_popcnt: combinational population count of an N-bit vector.
module votador_popcnt
   #(parameter int N = 3,
     parameter int W = 2)
   (input  logic [N-1:0] bits,
    output logic [W-1:0] cnt);

   // Sum the set bits.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) cnt = cnt + W'(bits[i]);
   end

endmodule

// File: rtl/votador_n.sv
// votador_n: session-framed N-voter majority voter with timeout.
// Optional macro VOTADOR_REVOTE_EN lets a voter change its ballot while the
// session is open; without it the first vote of each voter is final.
module votador_n
   import votador_n_pkg::*;
   #(parameter int N       = 3,
     parameter int QUORUM  = N / 2 + 1,
     parameter int TIMEOUT = DEF_TIMEOUT)
   (input logic        clk,
    input logic        reset,
    votador_n_if.slave bus);

   localparam int W    = cnt_w(N);
   localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int TMAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   state_t          state, state_n;
   logic            busy, busy_n, done, done_n, v, v_n, to, to_n;
   logic [N-1:0]    voted, voted_n;
   logic [W-1:0]    yes_cnt, yes_n, yes_vota, add_new;
   logic [TW-1:0]   timer, timer_n;
   logic [N-1:0]    fresh_yes;

   // First-time yes votes this cycle (vote_valid & ~voted & vote_val).
   assign fresh_yes = bus.vote_valid & ~voted & bus.vote_val;

   votador_popcnt #(.N(N), .W(W)) u_pop_new (.bits(fresh_yes), .cnt(add_new));

`ifdef VOTADOR_REVOTE_EN
   logic [N-1:0] ballot, ballot_n, rv_up, rv_dn;
   logic [W-1:0] add_up, add_dn;

   // Re-votes flipping no->yes add one, yes->no remove one.
   assign rv_up = bus.vote_valid & voted & bus.vote_val & ~ballot;
   assign rv_dn = bus.vote_valid & voted & ~bus.vote_val & ballot;

   votador_popcnt #(.N(N), .W(W)) u_pop_up (.bits(rv_up), .cnt(add_up));
   votador_popcnt #(.N(N), .W(W)) u_pop_dn (.bits(rv_dn), .cnt(add_dn));

   assign yes_vota = yes_cnt + add_new + add_up - add_dn;
`else
   assign yes_vota = yes_cnt + add_new;
`endif

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         v       <= 1'b0;
         to      <= 1'b0;
         voted   <= '0;
         yes_cnt <= '0;
         timer   <= '0;
`ifdef VOTADOR_REVOTE_EN
         ballot  <= '0;
`endif
      end else begin
         state   <= state_n;
         busy    <= busy_n;
         done    <= done_n;
         v       <= v_n;
         to      <= to_n;
         voted   <= voted_n;
         yes_cnt <= yes_n;
         timer   <= timer_n;
`ifdef VOTADOR_REVOTE_EN
         ballot  <= ballot_n;
`endif
      end
   end

   // Next state and next output values; close checks use this cycle's votes.
   always_comb begin
      state_n  = state;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      v_n      = v;
      to_n     = to;
      voted_n  = voted;
      yes_n    = yes_cnt;
      timer_n  = timer;
`ifdef VOTADOR_REVOTE_EN
      ballot_n = ballot;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_n  = VOTA;
               busy_n   = 1'b1;
               voted_n  = '0;
               yes_n    = '0;
               timer_n  = '0;
               v_n      = 1'b0;
               to_n     = 1'b0;
`ifdef VOTADOR_REVOTE_EN
               ballot_n = '0;
`endif
            end
         end
         VOTA: begin
            busy_n   = 1'b1;
            voted_n  = voted | bus.vote_valid;
            yes_n    = yes_vota;
            timer_n  = timer + 1'b1;
`ifdef VOTADOR_REVOTE_EN
            ballot_n = (ballot & ~bus.vote_valid) | (bus.vote_valid & bus.vote_val);
`endif
            // all_voted takes priority over a simultaneous timeout.
            if (&voted_n) begin
               state_n = FIN;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               v_n     = (yes_vota >= W'(QUORUM));
               to_n    = 1'b0;
            end else if (TIMEOUT != 0 && timer == TW'(TMAX)) begin
               state_n = FIN;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               v_n     = (yes_vota >= W'(QUORUM));
               to_n    = 1'b1;
            end
         end
         FIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.v         = v;
   assign bus.timed_out = to;
   assign bus.voted     = voted;
   assign bus.yes_cnt   = yes_cnt;

endmodule

// File: tb/tb_votador_n.sv
// Directed self-checking bench for votador_n; three instances cover the
// default N=3 build, a timeout case (N=5) and the all_voted/timeout tie (N=4).
module tb_votador_n;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   votador_n_if #(.N(3)) b3 ();
   votador_n_if #(.N(5)) b5 ();
   votador_n_if #(.N(4)) b4 ();

   votador_n u3 (.clk(clk), .reset(reset), .bus(b3));
   votador_n #(.N(5), .QUORUM(3), .TIMEOUT(4)) u5 (.clk(clk), .reset(reset), .bus(b5));
   votador_n #(.N(4), .QUORUM(2), .TIMEOUT(2)) u4 (.clk(clk), .reset(reset), .bus(b4));

`ifdef VOTADOR_REVOTE_EN
   localparam int REVOTE_YES = 0;
`else
   localparam int REVOTE_YES = 1;
`endif

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      n_checks++; if (b3.busy !== 1'b0 || b3.done !== 1'b0 || b3.v !== 1'b0) begin n_fail++; $display("FAIL rst3_flags: busy=%b done=%b v=%b exp 0", b3.busy, b3.done, b3.v); end
      n_checks++; if (b3.voted !== 3'b000 || b3.yes_cnt !== 2'd0 || b3.timed_out !== 1'b0) begin n_fail++; $display("FAIL rst3_regs: voted=%b yes=%0d to=%b exp 0", b3.voted, b3.yes_cnt, b3.timed_out); end
      n_checks++; if (b5.busy !== 1'b0 || b5.voted !== 5'b0 || b5.yes_cnt !== 3'd0) begin n_fail++; $display("FAIL rst5: busy=%b voted=%b yes=%0d exp 0", b5.busy, b5.voted, b5.yes_cnt); end
      n_checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.yes_cnt !== 3'd0) begin n_fail++; $display("FAIL rst4: busy=%b done=%b yes=%0d exp 0", b4.busy, b4.done, b4.yes_cnt); end
      reset = 1'b0;
      // Mid-session reset after one yes vote.
      b3.start = 1'b1; step(); b3.start = 1'b0;
      b3.vote_valid = 3'b001; b3.vote_val = 3'b001; step();
      b3.vote_valid = 3'b000; b3.vote_val = 3'b000;
      n_checks++; if (b3.yes_cnt !== 2'd1 || b3.busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: yes=%0d busy=%b exp 1 1", b3.yes_cnt, b3.busy); end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (b3.busy !== 1'b0 || b3.done !== 1'b0 || b3.yes_cnt !== 2'd0 || b3.voted !== 3'b000) begin n_fail++; $display("FAIL rst_mid: busy=%b done=%b yes=%0d voted=%b exp all 0", b3.busy, b3.done, b3.yes_cnt, b3.voted); end
      end
      reset = 1'b0;
      step();
      n_checks++; if (b3.busy !== 1'b0 || b3.done !== 1'b0 || b3.v !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy=%b done=%b v=%b exp 0", b3.busy, b3.done, b3.v); end
   endtask

   task automatic test_all_vote();
      b3.start = 1'b1; step(); b3.start = 1'b0;
      n_checks++; if (b3.busy !== 1'b1) begin n_fail++; $display("FAIL av_busy: got %b exp 1", b3.busy); end
      b3.vote_valid = 3'b111; b3.vote_val = 3'b011; step();
      b3.vote_valid = 3'b000; b3.vote_val = 3'b000;
      n_checks++; if (b3.done !== 1'b1 || b3.busy !== 1'b0) begin n_fail++; $display("FAIL av_done: done=%b busy=%b exp 1 0", b3.done, b3.busy); end
      n_checks++; if (b3.v !== 1'b1 || b3.yes_cnt !== 2'd2 || b3.timed_out !== 1'b0) begin n_fail++; $display("FAIL av_res: v=%b yes=%0d to=%b exp 1 2 0", b3.v, b3.yes_cnt, b3.timed_out); end
      n_checks++; if (b3.voted !== 3'b111) begin n_fail++; $display("FAIL av_voted: got %b exp 111", b3.voted); end
      step();
      n_checks++; if (b3.done !== 1'b0 || b3.v !== 1'b1 || b3.yes_cnt !== 2'd2) begin n_fail++; $display("FAIL av_hold: done=%b v=%b yes=%0d exp 0 1 2", b3.done, b3.v, b3.yes_cnt); end
   endtask

   task automatic test_timeout();
      b5.start = 1'b1; step(); b5.start = 1'b0;
      b5.vote_valid = 5'b00011; b5.vote_val = 5'b00011; step();
      b5.vote_valid = 5'b0; b5.vote_val = 5'b0;
      step(); step();
      n_checks++; if (b5.done !== 1'b0 || b5.busy !== 1'b1) begin n_fail++; $display("FAIL to_early: done=%b busy=%b exp 0 1", b5.done, b5.busy); end
      step();
      n_checks++; if (b5.done !== 1'b1 || b5.timed_out !== 1'b1) begin n_fail++; $display("FAIL to_close: done=%b to=%b exp 1 1", b5.done, b5.timed_out); end
      n_checks++; if (b5.v !== 1'b0 || b5.yes_cnt !== 3'd2 || b5.voted !== 5'b00011) begin n_fail++; $display("FAIL to_res: v=%b yes=%0d voted=%b exp 0 2 00011", b5.v, b5.yes_cnt, b5.voted); end
      step();
      n_checks++; if (b5.done !== 1'b0 || b5.timed_out !== 1'b1) begin n_fail++; $display("FAIL to_hold: done=%b to=%b exp 0 1", b5.done, b5.timed_out); end
   endtask

   task automatic test_revote();
      b3.start = 1'b1; step(); b3.start = 1'b0;
      b3.vote_valid = 3'b100; b3.vote_val = 3'b100; step();
      n_checks++; if (b3.yes_cnt !== 2'd1 || b3.voted !== 3'b100) begin n_fail++; $display("FAIL rv_first: yes=%0d voted=%b exp 1 100", b3.yes_cnt, b3.voted); end
      b3.vote_val = 3'b000; step(); step();
      b3.vote_valid = 3'b000;
      n_checks++; if (b3.yes_cnt !== 2'(REVOTE_YES) || b3.voted !== 3'b100 || b3.busy !== 1'b1) begin n_fail++; $display("FAIL rv_again: yes=%0d voted=%b busy=%b exp %0d 100 1", b3.yes_cnt, b3.voted, b3.busy, REVOTE_YES); end
      b3.vote_valid = 3'b011; b3.vote_val = 3'b000; step();
      b3.vote_valid = 3'b000;
      n_checks++; if (b3.done !== 1'b1 || b3.v !== 1'b0 || b3.yes_cnt !== 2'(REVOTE_YES)) begin n_fail++; $display("FAIL rv_close: done=%b v=%b yes=%0d exp 1 0 %0d", b3.done, b3.v, b3.yes_cnt, REVOTE_YES); end
      step();
   endtask

   task automatic test_start_ignored();
      b3.start = 1'b1; step();
      b3.vote_valid = 3'b001; b3.vote_val = 3'b001; step();
      n_checks++; if (b3.busy !== 1'b1 || b3.voted !== 3'b001 || b3.yes_cnt !== 2'd1) begin n_fail++; $display("FAIL st_vota: busy=%b voted=%b yes=%0d exp 1 001 1", b3.busy, b3.voted, b3.yes_cnt); end
      b3.vote_valid = 3'b110; b3.vote_val = 3'b110; step();
      b3.vote_valid = 3'b000; b3.vote_val = 3'b000;
      n_checks++; if (b3.done !== 1'b1 || b3.v !== 1'b1 || b3.yes_cnt !== 2'd3) begin n_fail++; $display("FAIL st_close: done=%b v=%b yes=%0d exp 1 1 3", b3.done, b3.v, b3.yes_cnt); end
      step();
      n_checks++; if (b3.busy !== 1'b0 || b3.done !== 1'b0 || b3.v !== 1'b1 || b3.yes_cnt !== 2'd3) begin n_fail++; $display("FAIL st_fin: busy=%b done=%b v=%b yes=%0d exp 0 0 1 3", b3.busy, b3.done, b3.v, b3.yes_cnt); end
      step();
      b3.start = 1'b0;
      n_checks++; if (b3.busy !== 1'b1 || b3.v !== 1'b0 || b3.yes_cnt !== 2'd0 || b3.voted !== 3'b000) begin n_fail++; $display("FAIL st_new: busy=%b v=%b yes=%0d voted=%b exp 1 0 0 000", b3.busy, b3.v, b3.yes_cnt, b3.voted); end
      b3.vote_valid = 3'b111; b3.vote_val = 3'b000; step();
      b3.vote_valid = 3'b000;
      n_checks++; if (b3.done !== 1'b1 || b3.v !== 1'b0 || b3.yes_cnt !== 2'd0) begin n_fail++; $display("FAIL st_no: done=%b v=%b yes=%0d exp 1 0 0", b3.done, b3.v, b3.yes_cnt); end
      step();
   endtask

   task automatic test_tie_priority();
      b4.start = 1'b1; step(); b4.start = 1'b0;
      b4.vote_valid = 4'b0011; b4.vote_val = 4'b0001; step();
      n_checks++; if (b4.busy !== 1'b1 || b4.yes_cnt !== 3'd1 || b4.done !== 1'b0) begin n_fail++; $display("FAIL tie_mid: busy=%b yes=%0d done=%b exp 1 1 0", b4.busy, b4.yes_cnt, b4.done); end
      b4.vote_valid = 4'b1100; b4.vote_val = 4'b0100; step();
      b4.vote_valid = 4'b0000; b4.vote_val = 4'b0000;
      n_checks++; if (b4.done !== 1'b1 || b4.timed_out !== 1'b0) begin n_fail++; $display("FAIL tie_close: done=%b to=%b exp 1 0", b4.done, b4.timed_out); end
      n_checks++; if (b4.v !== 1'b1 || b4.yes_cnt !== 3'd2 || b4.voted !== 4'b1111) begin n_fail++; $display("FAIL tie_res: v=%b yes=%0d voted=%b exp 1 2 1111", b4.v, b4.yes_cnt, b4.voted); end
      step();
   endtask

   initial begin
      reset = 1'b1;
      b3.start = 1'b0; b3.vote_valid = '0; b3.vote_val = '0;
      b5.start = 1'b0; b5.vote_valid = '0; b5.vote_val = '0;
      b4.start = 1'b0; b4.vote_valid = '0; b4.vote_val = '0;
      test_reset();
      test_all_vote();
      test_timeout();
      test_revote();
      test_start_ignored();
      test_tie_priority();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
